// File: rtl/fc_output_layer_pkg.sv
// Shared CNN classifier definitions: class count, score width, FC state type,
// and the constant weight/bias tables that back fc_weight_rom.
package fc_output_layer_pkg;

    localparam int N_CLASSES = 10;
    localparam int ACC_W     = 54;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_BIAS  = 2'd2,
        S_OUT   = 2'd3
    } fc_state_e;

    // Weight table selectors for fc_weight_rom
    localparam int WSET_PATTERN = 0;  // deterministic mixed-sign pattern
    localparam int WSET_ONES    = 1;  // every weight 1, bias 0
    localparam int WSET_RAMP    = 2;  // w[c][i] = c-5, bias[c] = c
    localparam int WSET_MIN     = 3;  // every weight most-negative, bias 0

    function automatic int fc_weight(input int wset, input int wt_w, input int c, input int i);
        int w;
        case (wset)
            WSET_ONES: w = 1;
            WSET_RAMP: w = c - 5;
            WSET_MIN:  w = -(1 <<< (wt_w - 1));
            default:   w = ((c * 7 + i * 3) % 11) - 5;
        endcase
        return w;
    endfunction

    function automatic int fc_bias(input int wset, input int c);
        int b;
        case (wset)
            WSET_RAMP:    b = c;
            WSET_PATTERN: b = c - 4;
            default:      b = 0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fc_output_layer_weight_rom.sv
// Weight ROM for the FC output layer: one address per feature index returns
// all class weights one cycle later; biases are constant outputs.
module fc_weight_rom
    import fc_output_layer_pkg::*;
#(
    parameter int WT_W   = 16,
    parameter int WSET   = WSET_PATTERN,
    parameter int ADDR_W = 11
) (
    input  logic                   clk,
    input  logic [ADDR_W-1:0]      addr,
    output logic signed [WT_W-1:0] w_q  [N_CLASSES-1:0],
    output logic signed [WT_W-1:0] bias [N_CLASSES-1:0]
);

    logic signed [WT_W-1:0] w_d [N_CLASSES-1:0];

    // Table lookup for the addressed feature and the constant biases
    always_comb begin
        for (int c = 0; c < N_CLASSES; c++) begin
            w_d[c]  = WT_W'(fc_weight(WSET, WT_W, c, int'(addr)));
            bias[c] = WT_W'(fc_bias(WSET, c));
        end
    end

    // Registered read port: data appears the cycle after the address
    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

endmodule

// File: rtl/fc_output_layer.sv
// Fully-connected output layer: streams N_IN features, accumulates 10 class
// scores in parallel, adds biases and emits all scores with a one-cycle pulse.
// Handshake: a feature transfers on a rising edge where in_valid && in_ready;
// in_valid may drop at any time (a stall), in_ready never depends on in_valid.
module fc_output_layer #(
    parameter int N_IN  = 1152,
    parameter int IN_W  = 16,
    parameter int WT_W  = 16,
    parameter int ACC_W = fc_output_layer_pkg::ACC_W,
    parameter int WSET  = fc_output_layer_pkg::WSET_PATTERN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic signed [IN_W-1:0]         in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic signed [ACC_W-1:0]        out_data [fc_output_layer_pkg::N_CLASSES-1:0],
    output fc_output_layer_pkg::fc_state_e dbg_state
);
    import fc_output_layer_pkg::*;

    localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PROD_W = IN_W + WT_W;

    fc_state_e               state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [IN_W-1:0]  feat_q, feat_d;
    logic                    feat_v_q, feat_v_d;
    logic signed [ACC_W-1:0] acc_q      [N_CLASSES-1:0];
    logic signed [ACC_W-1:0] acc_d      [N_CLASSES-1:0];
    logic signed [ACC_W-1:0] out_data_q [N_CLASSES-1:0];
    logic signed [ACC_W-1:0] out_data_d [N_CLASSES-1:0];
    logic signed [WT_W-1:0]  w_rom      [N_CLASSES-1:0];
    logic signed [WT_W-1:0]  bias_rom   [N_CLASSES-1:0];
    logic signed [PROD_W-1:0] prod      [N_CLASSES-1:0];
    logic                    accept;
    logic                    last_feat;

    assign in_ready  = !rst && (state_q == S_IDLE || state_q == S_ACCUM);
    assign accept    = in_valid && in_ready;
    assign last_feat = (idx_q == IDX_W'(N_IN - 1));
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign dbg_state = state_q;

    fc_weight_rom #(
        .WT_W   (WT_W),
        .WSET   (WSET),
        .ADDR_W (IDX_W)
    ) u_rom (
        .clk  (clk),
        .addr (idx_q),
        .w_q  (w_rom),
        .bias (bias_rom)
    );

    // Full-precision products of the delayed feature and the ROM weights
    always_comb begin
        for (int c = 0; c < N_CLASSES; c++) begin
            prod[c] = PROD_W'(feat_q) * PROD_W'(w_rom[c]);
        end
    end

    // Next-state, feature pipeline, MAC and bias/output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        feat_d     = feat_q;
        feat_v_d   = accept;
        acc_d      = acc_q;
        out_data_d = out_data_q;

        if (accept) begin
            feat_d = in_data;
        end

        // The feature accepted last cycle now lines up with its ROM row
        if (feat_v_q) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                acc_d[c] = acc_q[c] + ACC_W'(prod[c]);
            end
        end

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    if (last_feat) begin
                        idx_d   = '0;
                        state_d = S_BIAS;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_ACCUM;
                    end
                end
            end
            S_BIAS: begin
                // Wait until the last product has landed in acc_q
                if (!feat_v_q) begin
                    for (int c = 0; c < N_CLASSES; c++) begin
                        out_data_d[c] = acc_q[c] + ACC_W'(bias_rom[c]);
                    end
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                acc_d   = '{default: '0};
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pipeline and score registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            feat_q     <= '0;
            feat_v_q   <= 1'b0;
            acc_q      <= '{default: '0};
            out_data_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            feat_q     <= feat_d;
            feat_v_q   <= feat_v_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_fc_output_layer.sv
// Directed bench for fc_output_layer: two small-frame instances (unit weights,
// ramp weights) share one feature stream; a full-size instance with
// most-negative weights checks the no-wrap corner.
module tb_fc_output_layer;
    import fc_output_layer_pkg::*;

    localparam int     N_SMALL   = 4;
    localparam int     N_BIG     = 1152;
    localparam longint MAX_SCORE = 64'sd1236950581248;  // 1152 * 2^30

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] in_data;

    logic in_ready_a, in_ready_b, in_ready_c;
    logic out_valid_a, out_valid_b, out_valid_c;
    logic signed [ACC_W-1:0] out_data_a [N_CLASSES-1:0];
    logic signed [ACC_W-1:0] out_data_b [N_CLASSES-1:0];
    logic signed [ACC_W-1:0] out_data_c [N_CLASSES-1:0];
    fc_state_e dbg_state_a, dbg_state_b, dbg_state_c;

    logic signed [ACC_W-1:0] exp_q [$];

    int n_checks;
    int n_errors;
    int n_cyc;
    int pulse_cnt_a;
    int pulse_last_a;
    int pulse_prev_a;
    int pulse_cnt_c;
    int pulse_last_c;
    int last_acc;
    int p0;

    fc_output_layer #(.N_IN(N_SMALL), .WSET(WSET_ONES)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
        .dbg_state(dbg_state_a)
    );

    fc_output_layer #(.N_IN(N_SMALL), .WSET(WSET_RAMP)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
        .dbg_state(dbg_state_b)
    );

    fc_output_layer #(.N_IN(N_BIG), .WSET(WSET_MIN)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_c), .out_valid(out_valid_c), .out_data(out_data_c),
        .dbg_state(dbg_state_c)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge and log output pulses
    task automatic tick();
        @(negedge clk);
        n_cyc++;
        if (out_valid_a) begin
            pulse_cnt_a++;
            pulse_prev_a = pulse_last_a;
            pulse_last_a = n_cyc;
        end
        if (out_valid_c) begin
            pulse_cnt_c++;
            pulse_last_c = n_cyc;
        end
    endtask

    // Offer one feature and hold it until the selected instance takes it
    task automatic feed(input logic signed [15:0] v, input bit use_c);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!(use_c ? in_ready_c : in_ready_a) && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check("feed_timeout", guard, 0);
        tick();
        last_acc = n_cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_pulse_a(input string tag);
        int guard;
        guard = 0;
        while (!out_valid_a && guard < 40) begin
            tick();
            guard++;
        end
        check($sformatf("%s_pulse", tag), out_valid_a, 1);
    endtask

    // Scoreboard: u_a scores equal the feature sum; u_b is sum*(c-5)+c
    task automatic check_frame(input string tag);
        longint s;
        check($sformatf("%s_exp_avail", tag), exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            for (int c = 0; c < N_CLASSES; c++) begin
                check($sformatf("%s_a%0d", tag, c), out_data_a[c], s);
                check($sformatf("%s_b%0d", tag, c), out_data_b[c], s * (c - 5) + c);
            end
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; n_cyc = 0;
        pulse_cnt_a = 0; pulse_last_a = 0; pulse_prev_a = 0;
        pulse_cnt_c = 0; pulse_last_c = 0; last_acc = 0; p0 = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;

        // Reset
        repeat (3) tick();
        check("rst_ready_a", in_ready_a, 0);
        check("rst_ready_c", in_ready_c, 0);
        rst = 1'b0;
        tick();
        pulse_cnt_a = 0; pulse_cnt_c = 0;
        check("rst_state_a", dbg_state_a, S_IDLE);
        check("rst_state_b", dbg_state_b, S_IDLE);
        check("rst_state_c", dbg_state_c, S_IDLE);
        check("rst_valid_a", out_valid_a, 0);
        check("rst_valid_c", out_valid_c, 0);
        check("rst_data_a0", out_data_a[0], 0);
        check("rst_data_b9", out_data_b[9], 0);
        check("rst_data_c5", out_data_c[5], 0);
        check("idle_ready_a", in_ready_a, 1);
        check("idle_ready_b", in_ready_b, 1);

        // Frame 1,2,3,4 back to back; keep offering 100 through BIAS/OUT
        for (int i = 1; i <= 4; i++) begin
            feed(16'(i), 1'b0);
            if (i == 1) check("t1_state_accum", dbg_state_a, S_ACCUM);
        end
        exp_q.push_back(10);
        in_valid = 1'b1;
        in_data  = 16'sd100;
        check("t1_ready_bias", in_ready_a, 0);
        check("t1_state_bias", dbg_state_a, S_BIAS);
        tick();
        check("t1_ready_bias2", in_ready_a, 0);
        check("t1_valid_early", out_valid_a, 0);
        tick();
        // Pulse occupies the third cycle after the accepting edge
        check("t1_latency", n_cyc - last_acc, 2);
        check("t1_valid", out_valid_a, 1);
        check("t1_valid_b", out_valid_b, 1);
        check("t1_ready_out", in_ready_a, 0);
        check("t1_state_out", dbg_state_a, S_OUT);
        in_valid = 1'b0;
        check_frame("t1");
        tick();
        check("t1_pulse_width", out_valid_a, 0);
        check("t1_hold", out_data_a[3], 10);
        check("t1_state_idle", dbg_state_a, S_IDLE);

        // Frame of -3s; the offered 100s above must not have been taken
        for (int i = 0; i < 4; i++) feed(-16'sd3, 1'b0);
        exp_q.push_back(-12);
        wait_pulse_a("t2");
        check("t2_latency", n_cyc - last_acc, 2);
        check_frame("t2");

        // Frame 1,2,3,4 with in_valid toggling; gap data must be ignored
        for (int i = 1; i <= 4; i++) begin
            feed(16'(i), 1'b0);
            if (i < 4) begin
                in_data = 16'sd77;
                tick();
                check($sformatf("t3_gap_state%0d", i), dbg_state_a, S_ACCUM);
            end
        end
        exp_q.push_back(10);
        wait_pulse_a("t3");
        check("t3_latency", n_cyc - last_acc, 2);
        check_frame("t3");

        // Two frames back to back: 1s then 2s
        p0 = pulse_cnt_a;
        for (int i = 0; i < 4; i++) feed(16'sd1, 1'b0);
        exp_q.push_back(4);
        feed(16'sd2, 1'b0);
        check("t4_pulse1_count", pulse_cnt_a, p0 + 1);
        check_frame("t4f1");
        for (int i = 1; i < 4; i++) feed(16'sd2, 1'b0);
        exp_q.push_back(8);
        tick();
        check("t4_hold", out_data_a[0], 4);
        check("t4_no_pulse_yet", out_valid_a, 0);
        tick();
        check("t4_valid2", out_valid_a, 1);
        check("t4_spacing", pulse_last_a - pulse_prev_a, N_SMALL + 3);
        check_frame("t4f2");

        // Reset after 2 of 4 features, then a clean frame of 1s
        feed(16'sd5, 1'b0);
        feed(16'sd5, 1'b0);
        rst = 1'b1;
        tick();
        check("t5_ready_rst", in_ready_a, 0);
        rst = 1'b0;
        p0 = pulse_cnt_a;
        tick();
        check("t5_state_idle", dbg_state_a, S_IDLE);
        for (int i = 0; i < 4; i++) feed(16'sd1, 1'b0);
        exp_q.push_back(4);
        wait_pulse_a("t5");
        check("t5_pulse_count", pulse_cnt_a, p0 + 1);
        check_frame("t5");

        // Full-size frame of most-negative features into most-negative weights
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        p0 = pulse_cnt_c;
        for (int i = 0; i < N_BIG; i++) feed(16'sh8000, 1'b1);
        begin
            int guard;
            guard = 0;
            while (!out_valid_c && guard < 40) begin
                tick();
                guard++;
            end
        end
        check("t6_pulse", out_valid_c, 1);
        check("t6_pulse_count", pulse_cnt_c, p0 + 1);
        check("t6_latency", pulse_last_c - last_acc, 2);
        for (int c = 0; c < N_CLASSES; c++) begin
            check($sformatf("t6_c%0d", c), out_data_c[c], MAX_SCORE);
        end

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
